// File: rtl/joydb9_serial_reader.sv
// Serial reader for two DB9 joysticks behind a 74HC165 shift-register chain.
// Each frame: parallel-load the chain, clock out 16 bits, then idle for GAP_TICKS
// serial ticks. Buttons on the chain are active-low; the outputs are active-high.
//
// Ports:
//   clk          system clock (only clock)
//   reset        synchronous, active-high reset
//   joy_data     serial data from the chain (active-low buttons)
//   joy_clk      serial shift clock to the chain (registered)
//   joy_load_n   parallel-load strobe to the chain, active-low (registered)
//   joy1, joy2   committed joystick states, 1 = pressed
//                bit0 up, bit1 down, bit2 left, bit3 right,
//                bit4 fire1, bit5 fire2, bit6 fire3, bit7 start
//   frame_strobe one-cycle pulse in the cycle joy1/joy2 take a new value
module joydb9_serial_reader #(
    parameter int unsigned CLK_DIV   = 25,
    parameter int unsigned GAP_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       joy_data,
    output logic       joy_clk,
    output logic       joy_load_n,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       frame_strobe
);

    localparam int unsigned DivW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        StLoad,
        StShiftLo,
        StShiftHi,
        StGap
    } state_e;

    state_e          state_q;
    logic [DivW-1:0] div_q;
    logic [7:0]      tick_cnt_q;  // ticks spent in LOAD or GAP
    logic [4:0]      bit_cnt_q;
    logic [15:0]     shreg_q;
    logic            commit_q;    // frame complete, publish on the next edge
    logic            tick;

    assign tick = (div_q == DivW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StLoad;
            div_q        <= '0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            commit_q     <= 1'b0;
            joy_clk      <= 1'b0;
            joy_load_n   <= 1'b1;
            joy1         <= '0;
            joy2         <= '0;
            frame_strobe <= 1'b0;
        end else begin
            // Divider free-runs regardless of state.
            div_q        <= tick ? '0 : div_q + DivW'(1);
            frame_strobe <= 1'b0;

            // Both joysticks are published together, only from a complete frame.
            if (commit_q) begin
                joy1         <= ~shreg_q[15:8];
                joy2         <= ~shreg_q[7:0];
                frame_strobe <= 1'b1;
                commit_q     <= 1'b0;
            end

            unique case (state_q)
                StLoad: begin
                    joy_clk <= 1'b0;
                    if (tick && tick_cnt_q == 8'd1) begin
                        state_q    <= StShiftLo;
                        joy_load_n <= 1'b1;
                        bit_cnt_q  <= '0;
                        tick_cnt_q <= '0;
                    end else begin
                        // Also pulls load low on the first cycle after reset.
                        joy_load_n <= 1'b0;
                        if (tick) begin
                            tick_cnt_q <= tick_cnt_q + 8'd1;
                        end
                    end
                end

                StShiftLo: begin
                    if (tick) begin
                        // First bit sampled ends up at shreg_q[15] after 16 shifts.
                        shreg_q <= {shreg_q[14:0], joy_data};
                        joy_clk <= 1'b1;
                        state_q <= StShiftHi;
                    end
                end

                StShiftHi: begin
                    if (tick) begin
                        joy_clk   <= 1'b0;
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            state_q    <= StGap;
                            tick_cnt_q <= '0;
                            commit_q   <= 1'b1;
                        end else begin
                            state_q <= StShiftLo;
                        end
                    end
                end

                StGap: begin
                    joy_clk <= 1'b0;
                    if (tick) begin
                        if (tick_cnt_q == 8'(GAP_TICKS - 1)) begin
                            state_q    <= StLoad;
                            tick_cnt_q <= '0;
                            joy_load_n <= 1'b0;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joydb9_serial_reader.sv
// Bench for joydb9_serial_reader: two instances (default timing and the fastest
// legal timing), each driven by a 74HC165 chain model. Expected joystick values
// are queued when a chain load completes and compared when frame_strobe fires.
module tb_joydb9_serial_reader;

    localparam int CD   = 25;
    localparam int GT   = 8;
    localparam int PER  = (34 + GT) * CD;
    localparam int CD2  = 2;
    localparam int GT2  = 1;
    localparam int PER2 = (34 + GT2) * CD2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rst_s = 1'b1;  // reset as the DUTs sampled it on the last edge

    always #5 clk = ~clk;
    always @(posedge clk) rst_s <= reset;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: default parameters ----------------
    logic        joy_data, joy_clk, joy_load_n, frame_strobe;
    logic [7:0]  joy1, joy2;
    logic [15:0] pat   = 16'hFFFF;
    logic [15:0] chain = 16'hFFFF;
    logic        jclk_q = 1'b0;

    joydb9_serial_reader #(.CLK_DIV(CD), .GAP_TICKS(GT)) dut (
        .clk          (clk),
        .reset        (reset),
        .joy_data     (joy_data),
        .joy_clk      (joy_clk),
        .joy_load_n   (joy_load_n),
        .joy1         (joy1),
        .joy2         (joy2),
        .frame_strobe (frame_strobe)
    );

    // 74HC165 chain: parallel load while load_n low, shift on joy_clk rise.
    always @(posedge clk) begin
        jclk_q <= joy_clk;
        if (!joy_load_n) chain <= pat;
        else if (joy_clk && !jclk_q) chain <= {chain[14:0], 1'b1};
    end
    assign joy_data = chain[15];

    logic [15:0] q[$];
    logic [15:0] held = '0;
    logic [15:0] exp_v;
    logic        prev_ld = 1'b1, prev_jc = 1'b0, prev_fs = 1'b0, first_pending = 1'b1;
    int          cyc = 0, since = 0, last_strobe = 0, rises = 0, lows = 0, nstrobe = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_s) begin
            check("rst_out", {13'd0, joy_clk, joy_load_n, frame_strobe, joy1, joy2},
                  {13'd0, 1'b0, 1'b1, 1'b0, 16'h0000});
            q.delete();
            held = '0;
            since = 0;
            first_pending = 1'b1;
            rises = 0;
            lows = 0;
            prev_ld = 1'b1;
            prev_jc = 1'b0;
            prev_fs = 1'b0;
        end else begin
            since++;
            if (!prev_ld && joy_load_n) q.push_back(~chain);
            if (!joy_load_n) lows++;
            if (joy_clk && !prev_jc) rises++;
            if (frame_strobe) begin
                nstrobe++;
                check("strobe_width", {31'd0, prev_fs}, 32'd0);
                if (q.size() == 0) begin
                    check("strobe_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_v = q.pop_front();
                    check("joy1", {24'd0, joy1}, {24'd0, exp_v[15:8]});
                    check("joy2", {24'd0, joy2}, {24'd0, exp_v[7:0]});
                    held = exp_v;
                end
                if (first_pending) begin
                    check("first_latency", since, 34 * CD + 1);
                end else begin
                    check("period", cyc - last_strobe, PER);
                    check("jclk_rises", rises, 16);
                    check("load_low_cycles", lows, 2 * CD);
                end
                first_pending = 1'b0;
                last_strobe = cyc;
                rises = 0;
                lows = 0;
            end else begin
                check("hold", {16'd0, joy1, joy2}, {16'd0, held});
            end
            prev_ld = joy_load_n;
            prev_jc = joy_clk;
            prev_fs = frame_strobe;
        end
    end

    // ---------------- instance B: CLK_DIV=2, GAP_TICKS=1 ----------------
    logic        joy_data2, joy_clk2, joy_load_n2, frame_strobe2;
    logic [7:0]  joy1b, joy2b;
    logic [15:0] pat2   = ~{8'hA5, 8'h3C};
    logic [15:0] chain2 = 16'hFFFF;
    logic        jclk2_q = 1'b0;

    joydb9_serial_reader #(.CLK_DIV(CD2), .GAP_TICKS(GT2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .joy_data     (joy_data2),
        .joy_clk      (joy_clk2),
        .joy_load_n   (joy_load_n2),
        .joy1         (joy1b),
        .joy2         (joy2b),
        .frame_strobe (frame_strobe2)
    );

    always @(posedge clk) begin
        jclk2_q <= joy_clk2;
        if (!joy_load_n2) chain2 <= pat2;
        else if (joy_clk2 && !jclk2_q) chain2 <= {chain2[14:0], 1'b1};
    end
    assign joy_data2 = chain2[15];

    logic [15:0] q2[$];
    logic [15:0] held2 = '0;
    logic [15:0] exp2;
    logic        prev_ld2 = 1'b1, first2 = 1'b1, tog2 = 1'b0;
    int          since2 = 0, last2 = 0;

    always @(negedge clk) begin
        if (rst_s) begin
            check("b_rst_out", {14'd0, joy_clk2, joy_load_n2, joy1b, joy2b},
                  {14'd0, 1'b0, 1'b1, 16'h0000});
            q2.delete();
            held2 = '0;
            since2 = 0;
            first2 = 1'b1;
            prev_ld2 = 1'b1;
        end else begin
            since2++;
            if (!prev_ld2 && joy_load_n2) q2.push_back(~chain2);
            if (frame_strobe2) begin
                if (q2.size() == 0) begin
                    check("b_strobe_unexpected", 32'd1, 32'd0);
                end else begin
                    exp2 = q2.pop_front();
                    check("b_joy1", {24'd0, joy1b}, {24'd0, exp2[15:8]});
                    check("b_joy2", {24'd0, joy2b}, {24'd0, exp2[7:0]});
                    held2 = exp2;
                end
                if (first2) check("b_first_latency", since2, 34 * CD2 + 1);
                else check("b_period", cyc - last2, PER2);
                first2 = 1'b0;
                last2 = cyc;
                // Alternate the pressed-button pattern between A5/3C and 3C/A5.
                tog2 = ~tog2;
                pat2 = tog2 ? ~{8'h3C, 8'hA5} : ~{8'hA5, 8'h3C};
            end else begin
                check("b_hold", {16'd0, joy1b, joy2b}, {16'd0, held2});
            end
            prev_ld2 = joy_load_n2;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_strobes(input int n, input int lim);
        int start;
        int k;
        start = nstrobe;
        k = 0;
        while (nstrobe < start + n && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (nstrobe < start + n) check("strobe_timeout", nstrobe - start, n);
    endtask

    task automatic wait_load_rise();
        int  k;
        logic p;
        k = 0;
        p = joy_load_n;
        while (!(joy_load_n && !p) && k < 3000) begin
            p = joy_load_n;
            @(posedge clk);
            #1;
            k++;
        end
        if (!(joy_load_n && !p)) check("load_rise_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_jclk_rises(input int n);
        int   k;
        int   r;
        logic p;
        k = 0;
        r = 0;
        p = joy_clk;
        while (r < n && k < 3000) begin
            @(posedge clk);
            #1;
            if (joy_clk && !p) r++;
            p = joy_clk;
            k++;
        end
        if (r < n) check("jclk_timeout", r, n);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;

        // No buttons pressed.
        wait_strobes(1, 2 * PER);

        // joy1 fire1+up, joy2 right.
        pat = ~{8'h11, 8'h08};
        wait_strobes(1, 2 * PER);

        // Pattern changes mid-shift; outputs must never show a mix.
        wait_load_rise();
        wait_jclk_rises(4);
        pat = ~{8'h5A, 8'hC3};
        wait_strobes(2, 3 * PER);
        wait_strobes(2, 3 * PER);

        // Reset during the 9th SHIFT_HI aborts the frame.
        pat = ~{8'h81, 8'h7E};
        wait_load_rise();
        wait_jclk_rises(9);
        #1 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        wait_strobes(1, 2 * PER);
        wait_strobes(1, 2 * PER);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
